// File: rtl/ts4231_multi_configurator.sv
// Configures NUM_SENSORS TS4231 front ends in parallel. It waits for light,
// bit-bangs CFG_WORD over E/D, reads it back and compares it. Failing channels
// are retried up to MAX_RETRIES times.
// Ports: clk, rst_n (async, active-low); e_in/d_in pad inputs;
//        e_out/e_oe, d_out/d_oe pad drive values and enables (1 = drive);
//        busy (sequence running), done (sticky), cfg_ok (per-channel pass).
module ts4231_multi_configurator #(
    parameter int unsigned          NUM_SENSORS   = 4,
    parameter int unsigned          CFG_WIDTH     = 15,
    parameter logic [CFG_WIDTH-1:0] CFG_WORD      = CFG_WIDTH'(15'h392B),
    parameter int unsigned          PHASE_CYCLES  = 6,
    parameter int unsigned          LIGHT_TIMEOUT = 1000000,
    parameter int unsigned          MAX_RETRIES   = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_SENSORS-1:0] e_in,
    output logic [NUM_SENSORS-1:0] e_out,
    output logic [NUM_SENSORS-1:0] e_oe,
    input  logic [NUM_SENSORS-1:0] d_in,
    output logic [NUM_SENSORS-1:0] d_out,
    output logic [NUM_SENSORS-1:0] d_oe,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_SENSORS-1:0] cfg_ok
);

    localparam int unsigned PH_W  = $clog2(PHASE_CYCLES);
    localparam int unsigned BIT_W = $clog2(CFG_WIDTH + 1);
    localparam int unsigned RET_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int unsigned TO_W  = $clog2(LIGHT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_WAIT_LIGHT,
        S_WRITE,
        S_READ,
        S_CHECK,
        S_DONE
    } state_t;

    // Section of one 3*CFG_WIDTH+5 phase transfer
    typedef enum logic [1:0] {
        SEC_START,
        SEC_BITS,
        SEC_STOP
    } sec_t;

    state_t                               state_q, state_d;
    sec_t                                 sec_q, sec_d;
    logic [1:0]                           sub_q, sub_d;
    logic [PH_W-1:0]                      ph_q, ph_d;
    logic [BIT_W-1:0]                     bit_q, bit_d;
    logic [RET_W-1:0]                     retry_q, retry_d;
    logic [TO_W-1:0]                      to_q, to_d;
    logic [NUM_SENSORS-1:0]               lit_q, lit_d;
    logic [NUM_SENSORS-1:0]               mask_q, mask_d;
    logic [NUM_SENSORS-1:0]               ok_q, ok_d;
    logic [NUM_SENSORS-1:0][CFG_WIDTH-1:0] sr_q, sr_d;
    logic [NUM_SENSORS-1:0]               e_s1_q, e_s2_q, e_s3_q, d_s1_q, d_s2_q;
    logic [NUM_SENSORS-1:0]               e_out_q, e_out_d, e_oe_q, e_oe_d;
    logic [NUM_SENSORS-1:0]               d_out_q, d_out_d, d_oe_q, d_oe_d;
    logic                                 busy_q, busy_d, done_q, done_d;

    logic [NUM_SENSORS-1:0] pass_c, remain_c;
    logic                   seq_end_c;
    logic [BIT_W-1:0]       wb_idx_c;
    logic [2:0]             lines_c;

    // Per-phase line levels, packed as {E, D, D drive enable}
    function automatic logic [2:0] bus_lines(input sec_t sec, input logic [1:0] sub,
                                             input logic wbit, input logic rd);
        logic [2:0] l;
        l = 3'b001;
        case (sec)
            SEC_START: begin
                case (sub)
                    2'd0:    l = 3'b111;
                    2'd1:    l = 3'b101;
                    default: l = 3'b001;
                endcase
            end
            SEC_BITS: l = {sub == 2'd1, wbit & ~rd, ~rd};
            SEC_STOP: l = (sub == 2'd0) ? 3'b101 : 3'b111;
            default:  l = 3'b001;
        endcase
        return l;
    endfunction

    // Next-state, counters and registered-output values
    always_comb begin
        state_d   = state_q;
        sec_d     = sec_q;
        sub_d     = sub_q;
        ph_d      = ph_q;
        bit_d     = bit_q;
        retry_d   = retry_q;
        to_d      = to_q;
        lit_d     = lit_q;
        mask_d    = mask_q;
        ok_d      = ok_q;
        sr_d      = sr_q;
        pass_c    = '0;
        remain_c  = '0;
        seq_end_c = 1'b0;

        case (state_q)
            S_WAIT_LIGHT: begin
                // A channel lighting on the timeout cycle still counts as lit
                lit_d = lit_q | (e_s2_q & ~e_s3_q);
                sec_d = SEC_START;
                sub_d = '0;
                ph_d  = '0;
                bit_d = '0;
                if (&lit_d) begin
                    state_d = S_WRITE;
                    mask_d  = lit_d;
                end else if (to_q == TO_W'(LIGHT_TIMEOUT - 1)) begin
                    to_d = '0;
                    if (|lit_d) begin
                        state_d = S_WRITE;
                        mask_d  = lit_d;
                    end
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end

            S_WRITE, S_READ: begin
                // Capture readback on the last cycle of the E-high phase
                if (state_q == S_READ && sec_q == SEC_BITS && sub_q == 2'd1 &&
                    ph_q == PH_W'(PHASE_CYCLES - 1)) begin
                    for (int i = 0; i < int'(NUM_SENSORS); i++) begin
                        sr_d[i] = {sr_q[i][CFG_WIDTH-2:0], d_s2_q[i]};
                    end
                end
                if (ph_q == PH_W'(PHASE_CYCLES - 1)) begin
                    ph_d = '0;
                    case (sec_q)
                        SEC_START: begin
                            if (sub_q == 2'd2) begin
                                sec_d = SEC_BITS;
                                sub_d = '0;
                                bit_d = '0;
                            end else begin
                                sub_d = sub_q + 2'd1;
                            end
                        end
                        SEC_BITS: begin
                            if (sub_q == 2'd2) begin
                                sub_d = '0;
                                if (bit_q == BIT_W'(CFG_WIDTH - 1)) begin
                                    sec_d = SEC_STOP;
                                end else begin
                                    bit_d = bit_q + BIT_W'(1);
                                end
                            end else begin
                                sub_d = sub_q + 2'd1;
                            end
                        end
                        SEC_STOP: begin
                            if (sub_q == 2'd1) begin
                                seq_end_c = 1'b1;
                            end else begin
                                sub_d = sub_q + 2'd1;
                            end
                        end
                        default: sec_d = SEC_START;
                    endcase
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
                if (seq_end_c) begin
                    sec_d   = SEC_START;
                    sub_d   = '0;
                    bit_d   = '0;
                    state_d = (state_q == S_WRITE) ? S_READ : S_CHECK;
                end
            end

            S_CHECK: begin
                for (int i = 0; i < int'(NUM_SENSORS); i++) begin
                    pass_c[i] = mask_q[i] && (sr_q[i] == CFG_WORD);
                end
                ok_d     = ok_q | pass_c;
                remain_c = mask_q & ~pass_c;
                if (remain_c == '0 || retry_q == RET_W'(MAX_RETRIES)) begin
                    state_d = S_DONE;
                    mask_d  = '0;
                end else begin
                    state_d = S_WRITE;
                    mask_d  = remain_c;
                    retry_d = retry_q + RET_W'(1);
                end
            end

            S_DONE:  state_d = S_DONE;
            default: state_d = S_WAIT_LIGHT;
        endcase

        // Outputs follow the next phase so pad levels line up with the counters
        wb_idx_c = BIT_W'(CFG_WIDTH - 1) - bit_d;
        lines_c  = bus_lines(sec_d, sub_d, CFG_WORD[wb_idx_c], state_d == S_READ);
        e_oe_d   = '0;
        e_out_d  = '0;
        d_oe_d   = '0;
        d_out_d  = '0;
        if (state_d == S_WRITE || state_d == S_READ) begin
            e_oe_d  = mask_d;
            e_out_d = mask_d & {NUM_SENSORS{lines_c[2]}};
            d_out_d = mask_d & {NUM_SENSORS{lines_c[1]}};
            d_oe_d  = mask_d & {NUM_SENSORS{lines_c[0]}};
        end else if (state_d == S_CHECK) begin
            // Hold the idle (1,1) level between transfers
            e_oe_d  = mask_d;
            e_out_d = mask_d;
            d_oe_d  = mask_d;
            d_out_d = mask_d;
        end
        busy_d = (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    // State, synchronisers and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT_LIGHT;
            sec_q   <= SEC_START;
            sub_q   <= '0;
            ph_q    <= '0;
            bit_q   <= '0;
            retry_q <= '0;
            to_q    <= '0;
            lit_q   <= '0;
            mask_q  <= '0;
            ok_q    <= '0;
            sr_q    <= '0;
            e_s1_q  <= '0;
            e_s2_q  <= '0;
            e_s3_q  <= '0;
            d_s1_q  <= '0;
            d_s2_q  <= '0;
            e_out_q <= '0;
            e_oe_q  <= '0;
            d_out_q <= '0;
            d_oe_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            sub_q   <= sub_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            retry_q <= retry_d;
            to_q    <= to_d;
            lit_q   <= lit_d;
            mask_q  <= mask_d;
            ok_q    <= ok_d;
            sr_q    <= sr_d;
            e_s1_q  <= e_in;
            e_s2_q  <= e_s1_q;
            e_s3_q  <= e_s2_q;
            d_s1_q  <= d_in;
            d_s2_q  <= d_s1_q;
            e_out_q <= e_out_d;
            e_oe_q  <= e_oe_d;
            d_out_q <= d_out_d;
            d_oe_q  <= d_oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign e_out  = e_out_q;
    assign e_oe   = e_oe_q;
    assign d_out  = d_out_q;
    assign d_oe   = d_oe_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign cfg_ok = ok_q;

endmodule
